// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared pipeline definitions: NOP encoding, PC step and the fetch FSM state encoding.
package fetch_stall_ctrl_pkg;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam int          PC_INC = 4;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stateT;

endpackage

// File: rtl/fetch_stall_ctrl_ifid_reg.sv
// Generic pipeline register with load enable, synchronous flush and a valid bit.
module ifid_reg #(
    parameter int              DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              load,
    input  logic              flush,
    input  logic [DATA_W-1:0] dIn,
    output logic [DATA_W-1:0] dOut,
    output logic              validOut
);

    // Flush wins over load so a redirect always leaves a bubble behind it.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            dOut     <= FLUSH_VAL;
            validOut <= 1'b0;
        end else if (flush) begin
            dOut     <= FLUSH_VAL;
            validOut <= 1'b0;
        end else if (load) begin
            dOut     <= dIn;
            validOut <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch stage: PC register, IF/ID register, load-use stall handling, redirects and stall statistics.
module fetch_stall_ctrl
    import fetch_stall_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              PCWrite,
    input  logic              IFIDWrite,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpTarget,
    input  logic [31:0]       Instruction,
    output logic [ADDR_W-1:0] PC,
    output logic [31:0]       IFID_Instruction,
    output logic [ADDR_W-1:0] IFID_PCPlus4,
    output logic              IFID_Valid,
    output logic              Stalled,
    output logic [CNT_W-1:0]  StallCount,
    output logic              ProtocolErr
);

    logic              redirect;
    logic [ADDR_W-1:0] redirectTarget;
    logic [ADDR_W-1:0] pcPlus4;
    logic              stallCycle;
    stateT             state;

    assign redirect       = BranchTaken | Jump;
    assign redirectTarget = BranchTaken ? BranchTarget : JumpTarget;
    assign pcPlus4        = PC + ADDR_W'(PC_INC);
    assign stallCycle     = !PCWrite && !redirect;
    assign Stalled        = (state == STALL);

    // A redirect overrides any stall request from the hazard unit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            PC <= PC_RESET;
        end else if (redirect) begin
            PC <= redirectTarget;
        end else if (PCWrite) begin
            PC <= pcPlus4;
        end
    end

    ifid_reg #(
        .DATA_W   (32 + ADDR_W),
        .FLUSH_VAL({NOP, {ADDR_W{1'b0}}})
    ) uIfid (
        .clk     (Clk),
        .rstN    (Reset_n),
        .load    (IFIDWrite),
        .flush   (redirect),
        .dIn     ({Instruction, pcPlus4}),
        .dOut    ({IFID_Instruction, IFID_PCPlus4}),
        .validOut(IFID_Valid)
    );

    // Mismatched write enables are still obeyed, but remembered until reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= RUN;
            StallCount  <= '0;
            ProtocolErr <= 1'b0;
        end else begin
            case (state)
                RUN:     if (stallCycle) state <= STALL;
                STALL:   if (!stallCycle) state <= RUN;
                default: state <= RUN;
            endcase
            if (stallCycle && (StallCount != {CNT_W{1'b1}})) begin
                StallCount <= StallCount + 1'b1;
            end
            if (!redirect && (PCWrite != IFIDWrite)) begin
                ProtocolErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Scoreboard bench for fetch_stall_ctrl: a reference model pushes expected snapshots, each test pops and compares.
module tb_fetch_stall_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        PCWrite, IFIDWrite, BranchTaken, Jump;
    logic [31:0] BranchTarget, JumpTarget, Instruction;
    logic [31:0] PC, IFID_Instruction, IFID_PCPlus4;
    logic        IFID_Valid, Stalled, ProtocolErr;
    logic [15:0] StallCount;
    logic [31:0] pc2, ifidInstr2, ifidP4b;
    logic        ifidValid2, stalled2, protoErr2;
    logic [1:0]  stallCount2;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        valid;
        logic        stalled;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        logic        err;
    } snapT;

    snapT expQ[$];
    snapT got, exp;

    // Reference model state
    logic [31:0] mPc, mInstr, mP4;
    logic        mValid, mStalled, mErr;
    logic [15:0] mCnt;
    logic [1:0]  mCnt2;

    always #5 Clk = ~Clk;

    function automatic logic [31:0] memFn(input logic [31:0] a);
        if (a == 32'h0) return 32'h8C08_0000;
        if (a == 32'h4) return 32'h0109_5020;
        return {a[15:0] ^ 16'h5A3C, a[15:0]};
    endfunction

    always_comb Instruction = memFn(PC);

    fetch_stall_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
        .Instruction(Instruction), .PC(PC), .IFID_Instruction(IFID_Instruction),
        .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid), .Stalled(Stalled),
        .StallCount(StallCount), .ProtocolErr(ProtocolErr)
    );

    fetch_stall_ctrl #(.CNT_W(2)) dutNarrow (
        .Clk(Clk), .Reset_n(Reset_n), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
        .Instruction(Instruction), .PC(pc2), .IFID_Instruction(ifidInstr2),
        .IFID_PCPlus4(ifidP4b), .IFID_Valid(ifidValid2), .Stalled(stalled2),
        .StallCount(stallCount2), .ProtocolErr(protoErr2)
    );

    function automatic snapT obsSnap();
        return {PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid, Stalled, StallCount, stallCount2, ProtocolErr};
    endfunction

    task automatic modelReset();
        mPc = 32'h0; mInstr = 32'h0; mP4 = 32'h0; mValid = 1'b0;
        mStalled = 1'b0; mErr = 1'b0; mCnt = '0; mCnt2 = '0;
    endtask

    // Drive one cycle of stimulus, predict the post-edge state, then step past the edge.
    task automatic applyStimulus(input logic pcw, input logic ifw, input logic br,
                                 input logic [31:0] bt, input logic j, input logic [31:0] jt);
        logic redir, stall;
        PCWrite = pcw; IFIDWrite = ifw; BranchTaken = br; BranchTarget = bt;
        Jump = j; JumpTarget = jt;
        redir = br | j;
        stall = !pcw && !redir;
        if (redir) begin
            mInstr = 32'h0; mP4 = 32'h0; mValid = 1'b0;
        end else if (ifw) begin
            mInstr = memFn(mPc); mP4 = mPc + 32'd4; mValid = 1'b1;
        end
        if (redir) mPc = br ? bt : jt;
        else if (pcw) mPc = mPc + 32'd4;
        mStalled = stall;
        if (stall && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
        if (stall && mCnt2 != 2'b11) mCnt2 = mCnt2 + 2'd1;
        if (!redir && (pcw != ifw)) mErr = 1'b1;
        expQ.push_back({mPc, mInstr, mP4, mValid, mStalled, mCnt, mCnt2, mErr});
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        PCWrite = 1'b1; IFIDWrite = 1'b1; BranchTaken = 1'b0; Jump = 1'b0;
        BranchTarget = '0; JumpTarget = '0;
        modelReset();
        repeat (2) @(posedge Clk);
        #1;
        got = obsSnap();
        vectors++;
        if (got !== snapT'(0)) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=%h", got, snapT'(0));
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_run_and_stall();
        logic [31:0] pcTab [4] = '{32'h4, 32'h8, 32'h8, 32'hC};
        for (int i = 0; i < 4; i++) begin
            if (i == 2) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
            else        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
            got = obsSnap();
            exp = expQ.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL run_stall[%0d] got=%h exp=%h", i, got, exp);
            end
            vectors++;
            if (PC !== pcTab[i]) begin
                miscompares++;
                $display("FAIL run_pc[%0d] got=%h exp=%h", i, PC, pcTab[i]);
            end
            if (i == 2) begin
                vectors++;
                if ({IFID_Instruction, Stalled, StallCount} !== {32'h0109_5020, 1'b1, 16'd1}) begin
                    miscompares++;
                    $display("FAIL stall_hold got=%h/%b/%0d exp=01095020/1/1",
                             IFID_Instruction, Stalled, StallCount);
                end
            end
        end
    endtask

    task automatic test_branch_in_stall();
        logic [15:0] cntBefore;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        cntBefore = StallCount;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, '0);
        for (int i = 0; i < 2; i++) begin
            got = obsSnap();
            exp = expQ.pop_front();
            if (i == 0) continue;
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL branch_in_stall got=%h exp=%h", got, exp);
            end
        end
        vectors++;
        if ({PC, IFID_Valid, IFID_Instruction, Stalled, StallCount} !== {32'h40, 1'b0, 32'h0, 1'b0, cntBefore}) begin
            miscompares++;
            $display("FAIL branch_flush pc=%h v=%b i=%h s=%b c=%0d exp pc=40 v=0 i=0 s=0 c=%0d",
                     PC, IFID_Valid, IFID_Instruction, Stalled, StallCount, cntBefore);
        end
    endtask

    task automatic test_redirect_priority();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            exp = expQ.pop_front();
            vectors++;
            if (exp.pc !== (i == 0 ? 32'h100 : i == 1 ? 32'hFFFF_FFFC : 32'h0)) begin
                miscompares++;
                $display("FAIL model_pc[%0d] got=%h", i, exp.pc);
            end
        end
        got = obsSnap();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL pc_wrap got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_protocol_err();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
            got = obsSnap();
            exp = expQ.pop_front();
            vectors++;
            if (got !== exp || ProtocolErr !== 1'b1) begin
                miscompares++;
                $display("FAIL protocol_err[%0d] got=%h exp=%h", i, got, exp);
            end
        end
        // Async reset between edges must clear everything without a clock.
        #2 Reset_n = 1'b0;
        #1;
        vectors++;
        if ({ProtocolErr, PC, IFID_Valid} !== {1'b0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_clear_err err=%b pc=%h v=%b exp 0/0/0", ProtocolErr, PC, IFID_Valid);
        end
        Reset_n = 1'b1;
        modelReset();
    endtask

    task automatic checkOutput();
        int narrowTab [6] = '{1, 2, 3, 3, 3, 3};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
            got = obsSnap();
            exp = expQ.pop_front();
            vectors++;
            if (got !== exp || stallCount2 !== 2'(narrowTab[i])) begin
                miscompares++;
                $display("FAIL saturate[%0d] cnt2=%0d exp=%0d got=%h exp=%h",
                         i, stallCount2, narrowTab[i], got, exp);
            end
        end
        #2 Reset_n = 1'b0;
        #1;
        vectors++;
        if ({PC, Stalled, StallCount, stallCount2, stalled2} !== {32'h0, 1'b0, 16'd0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_mid_stall pc=%h s=%b c=%0d c2=%0d exp 0/0/0/0", PC, Stalled, StallCount, stallCount2);
        end
        Reset_n = 1'b1;
        modelReset();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 5) == 0), {$urandom_range(0, 255), 2'b00},
                          ($urandom_range(0, 5) == 0), {$urandom_range(0, 255), 2'b00});
            got = obsSnap();
            exp = expQ.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL random[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_and_stall();
        test_branch_in_stall();
        test_redirect_priority();
        test_protocol_err();
        checkOutput();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
